// File: rtl/div_scheduler.sv
// div_scheduler: round-robin arbiter that shares one multi-cycle divider among
// NUM_REQ requesters. Requests arrive over per-requester valid/ready, one divide
// is in flight at a time, and each result returns tagged with its requester ID.
// Optional watchdog: define DIV_SCHED_TIMEOUT_EN to abort a divide that runs
// TIMEOUT cycles without completing; the response then carries rsp_timeout=1.
module div_scheduler #(
    parameter int unsigned SIZE    = 32,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 255,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*SIZE-1:0] req_dividend,
    input  logic [NUM_REQ*SIZE-1:0] req_divisor,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [SIZE-1:0]         rsp_quotient,
    output logic [SIZE-1:0]         rsp_remainder,
    output logic                    rsp_error,
    output logic                    rsp_timeout,
    output logic [SIZE-1:0]         div_dividend,
    output logic [SIZE-1:0]         div_divisor,
    output logic                    div_start,
    output logic                    div_abort,
    input  logic                    div_done,
    input  logic                    div_error,
    input  logic [SIZE-1:0]         div_quotient,
    input  logic [SIZE-1:0]         div_remainder
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] cur_id;
    logic            wait_first;

    logic            grant_found_c;
    logic [ID_W-1:0] grant_idx_c;
    logic [ID_W-1:0] ptr_nxt_c;
    logic            accept_c;
    logic            done_q_c;
    logic            expire_c;

    // Round-robin search: first valid requester at or after the pointer, wrapping
    always_comb begin
        logic [ID_W:0] cand;
        grant_found_c = 1'b0;
        grant_idx_c   = '0;
        cand          = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (ID_W+1)'(rr_ptr) + (ID_W+1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!grant_found_c && req_valid[cand[ID_W-1:0]]) begin
                grant_found_c = 1'b1;
                grant_idx_c   = cand[ID_W-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_found_c) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (done_q_c || expire_c) state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Grant, qualified-done and pointer-advance decode; grant is held off during reset
    always_comb begin
        logic [ID_W:0] inc;
        req_ready = '0;
        accept_c  = 1'b0;
        inc       = (ID_W+1)'(grant_idx_c) + (ID_W+1)'(1);
        ptr_nxt_c = (inc == NUM_REQ_W) ? '0 : inc[ID_W-1:0];
        if ((state == S_IDLE) && grant_found_c && reset) begin
            req_ready[grant_idx_c] = 1'b1;
            accept_c               = 1'b1;
        end
        // done may still be high from the previous op during the first WAIT cycle
        done_q_c = (state == S_WAIT) && div_done && !wait_first;
    end

    // Operand capture, start pulse and response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr        <= '0;
            cur_id        <= '0;
            wait_first    <= 1'b0;
            div_dividend  <= '0;
            div_divisor   <= '0;
            div_start     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_error     <= 1'b0;
        end else begin
            div_start  <= 1'b0;
            wait_first <= (state == S_ISSUE);
            if (accept_c) begin
                div_dividend <= req_dividend[32'(grant_idx_c) * SIZE +: SIZE];
                div_divisor  <= req_divisor[32'(grant_idx_c) * SIZE +: SIZE];
                cur_id       <= grant_idx_c;
                rr_ptr       <= ptr_nxt_c;
                div_start    <= 1'b1;
            end
            if (done_q_c) begin
                rsp_valid     <= 1'b1;
                rsp_id        <= cur_id;
                rsp_quotient  <= div_quotient;
                rsp_remainder <= div_remainder;
                rsp_error     <= div_error;
            end else if (expire_c) begin
                rsp_valid     <= 1'b1;
                rsp_id        <= cur_id;
                rsp_quotient  <= '0;
                rsp_remainder <= '0;
                rsp_error     <= 1'b1;
            end
            if ((state == S_RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef DIV_SCHED_TIMEOUT_EN
    localparam int unsigned        CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;

    // Expiry on the TIMEOUT-th WAIT cycle unless a qualified done arrives with it
    always_comb begin
        expire_c = (state == S_WAIT) && !done_q_c && (wait_cnt == CNT_LAST);
    end

    // WAIT-cycle counter, abort pulse and timeout flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt    <= '0;
            div_abort   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            div_abort <= expire_c;
            if (state == S_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (expire_c) begin
                rsp_timeout <= 1'b1;
            end else if (done_q_c) begin
                rsp_timeout <= 1'b0;
            end
        end
    end
`else
    assign expire_c    = 1'b0;
    assign div_abort   = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_div_scheduler.sv
// Directed bench for div_scheduler with a small behavioural divider model.
`timescale 1ns/1ps
module tb_div_scheduler;

    localparam int unsigned SIZE    = 32;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned LAT     = 3;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*SIZE-1:0] req_dividend;
    logic [NUM_REQ*SIZE-1:0] req_divisor;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [SIZE-1:0]         rsp_quotient;
    logic [SIZE-1:0]         rsp_remainder;
    logic                    rsp_error;
    logic                    rsp_timeout;
    logic [SIZE-1:0]         div_dividend;
    logic [SIZE-1:0]         div_divisor;
    logic                    div_start;
    logic                    div_abort;
    logic                    div_done;
    logic                    div_error;
    logic [SIZE-1:0]         div_quotient;
    logic [SIZE-1:0]         div_remainder;

    logic                    force_done;
    logic                    block_done;
    logic [3:0]              m_cnt;
    logic                    m_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    div_scheduler #(
        .SIZE    (SIZE),
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_error     (rsp_error),
        .rsp_timeout   (rsp_timeout),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_start     (div_start),
        .div_abort     (div_abort),
        .div_done      (div_done),
        .div_error     (div_error),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    // Divider model: done pulses LAT+1 edges after start; x/0 returns all-ones, dividend, error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt         <= '0;
            m_done        <= 1'b0;
            div_error     <= 1'b0;
            div_quotient  <= '0;
            div_remainder <= '0;
        end else begin
            m_done <= 1'b0;
            if (div_start) begin
                m_cnt <= 4'(LAT);
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 4'd1;
                if (m_cnt == 4'd1 && !block_done) begin
                    m_done <= 1'b1;
                    if (div_divisor == 0) begin
                        div_quotient  <= '1;
                        div_remainder <= div_dividend;
                        div_error     <= 1'b1;
                    end else begin
                        div_quotient  <= div_dividend / div_divisor;
                        div_remainder <= div_dividend % div_divisor;
                        div_error     <= 1'b0;
                    end
                end
            end
        end
    end

    assign div_done = m_done | force_done;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
        int r = -1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    // Present one request at a negedge, check its grant, drop valid after the grant edge
    task automatic grant_one(input int id, input logic [31:0] a, input logic [31:0] b);
        logic [NUM_REQ-1:0] exp_g;
        req_dividend[id*SIZE +: SIZE] = a;
        req_divisor[id*SIZE +: SIZE]  = b;
        req_valid                     = '0;
        req_valid[id]                 = 1'b1;
        exp_g                         = '0;
        exp_g[id]                     = 1'b1;
        #1;
        check("grant", 64'(req_ready), 64'(exp_g));
        @(negedge clk);
        req_valid = '0;
    endtask

    // Bounded wait for rsp_valid, counting start pulses seen on the way
    task automatic wait_rsp(output int starts);
        bit got;
        got    = 1'b0;
        starts = 0;
        for (int c = 0; c < 60; c++) begin
            if (div_start) starts++;
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rsp_wait", 64'(got), 64'd1);
    endtask

    initial begin
        int starts;
        int ng;
        int nr;
        int gnt[6];
        int rid[5];
        logic [31:0] rq[5];
        logic [31:0] rr[5];
        int exp_g[5] = '{0, 1, 2, 3, 0};
        logic [31:0] exp_q[5] = '{32'd33, 32'd27, 32'd24, 32'd21, 32'd33};
        logic [31:0] exp_r[5] = '{32'd1, 32'd2, 32'd0, 32'd4, 32'd1};
        bit stable;
        bit no_grant;

        req_valid    = '1;
        req_dividend = '0;
        req_divisor  = '0;
        rsp_ready    = 1'b1;
        force_done   = 1'b0;
        block_done   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_div_start", 64'(div_start), 64'd0);
        check("rst_div_abort", 64'(div_abort), 64'd0);
        check("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
        req_valid = '0;
        reset     = 1'b1;
        @(negedge clk);

        // Fairness: all valid, expect grants 0,1,2,3,0
        for (int i = 0; i < NUM_REQ; i++) begin
            req_dividend[i*SIZE +: SIZE] = 32'(100 + 10*i);
            req_divisor[i*SIZE +: SIZE]  = 32'(i + 3);
        end
        req_valid = '1;
        ng = 0;
        nr = 0;
        #1;
        for (int c = 0; c < 200; c++) begin
            if (req_ready != 0 && ng < 6) begin
                gnt[ng] = onehot_idx(req_ready);
                ng++;
            end
            if (rsp_valid) begin
                rid[nr] = int'(rsp_id);
                rq[nr]  = rsp_quotient;
                rr[nr]  = rsp_remainder;
                nr++;
            end
            if (nr == 5) break;
            @(negedge clk);
            #1;
        end
        req_valid = '0;
        check("rr_rsp_count", 64'(nr), 64'd5);
        check("rr_grant_count", 64'(ng), 64'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < ng) check("rr_grant_order", 64'(gnt[i]), 64'(exp_g[i]));
            if (i < nr) begin
                check("rr_rsp_id", 64'(rid[i]), 64'(exp_g[i]));
                check("rr_quotient", 64'(rq[i]), 64'(exp_q[i]));
                check("rr_remainder", 64'(rr[i]), 64'(exp_r[i]));
            end
        end
        @(negedge clk);

        // Single request 0: 100/7
        grant_one(0, 32'd100, 32'd7);
        wait_rsp(starts);
        check("single_starts", 64'(starts), 64'd1);
        check("single_id", 64'(rsp_id), 64'd0);
        check("single_quotient", 64'(rsp_quotient), 64'd14);
        check("single_remainder", 64'(rsp_remainder), 64'd2);
        check("single_error", 64'(rsp_error), 64'd0);
        @(negedge clk);
        check("single_rsp_drop", 64'(rsp_valid), 64'd0);

        // Divide by zero from requester 2
        grant_one(2, 32'd5, 32'd0);
        wait_rsp(starts);
        check("dz_id", 64'(rsp_id), 64'd2);
        check("dz_error", 64'(rsp_error), 64'd1);
        check("dz_timeout", 64'(rsp_timeout), 64'd0);
        check("dz_abort", 64'(div_abort), 64'd0);
        check("dz_quotient", 64'(rsp_quotient), 64'hFFFF_FFFF);
        check("dz_remainder", 64'(rsp_remainder), 64'd5);
        @(negedge clk);

        // Backpressure on requester 1 (50/6) with requester 3 waiting
        rsp_ready = 1'b0;
        grant_one(1, 32'd50, 32'd6);
        wait_rsp(starts);
        req_dividend[3*SIZE +: SIZE] = 32'd77;
        req_divisor[3*SIZE +: SIZE]  = 32'd10;
        req_valid[3]                 = 1'b1;
        stable   = 1'b1;
        no_grant = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!(rsp_valid === 1'b1 && rsp_id === 2'd1 && rsp_quotient === 32'd8 &&
                  rsp_remainder === 32'd2 && rsp_error === 1'b0)) stable = 1'b0;
            if (req_ready !== '0) no_grant = 1'b0;
        end
        check("bp_rsp_stable", 64'(stable), 64'd1);
        check("bp_no_grant", 64'(no_grant), 64'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_rsp_drop", 64'(rsp_valid), 64'd0);
        check("bp_next_grant", 64'(req_ready), 64'b1000);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(starts);
        check("bp_next_id", 64'(rsp_id), 64'd3);
        check("bp_next_quotient", 64'(rsp_quotient), 64'd7);
        check("bp_next_remainder", 64'(rsp_remainder), 64'd7);
        @(negedge clk);

        // Stale done held through ISSUE and the first WAIT cycle
        grant_one(0, 32'd9, 32'd2);
        force_done = 1'b1;
        @(negedge clk);
        check("stale_wait1", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("stale_ignored", 64'(rsp_valid), 64'd0);
        force_done = 1'b0;
        wait_rsp(starts);
        check("stale_quotient", 64'(rsp_quotient), 64'd4);
        check("stale_remainder", 64'(rsp_remainder), 64'd1);
        @(negedge clk);

`ifdef DIV_SCHED_TIMEOUT_EN
        // Watchdog: divider never completes
        block_done = 1'b1;
        grant_one(1, 32'd1, 32'd1);
        wait_rsp(starts);
        check("to_abort", 64'(div_abort), 64'd1);
        check("to_timeout", 64'(rsp_timeout), 64'd1);
        check("to_error", 64'(rsp_error), 64'd1);
        check("to_quotient", 64'(rsp_quotient), 64'd0);
        check("to_remainder", 64'(rsp_remainder), 64'd0);
        @(negedge clk);
        check("to_abort_pulse", 64'(div_abort), 64'd0);
        block_done = 1'b0;
        @(negedge clk);
`endif

        // Reset asserted mid-WAIT discards the operation and the pointer
        grant_one(2, 32'd1000, 32'd10);
        @(negedge clk);
        reset     = 1'b0;
        req_valid = '1;
        #1;
        check("mid_rst_req_ready", 64'(req_ready), 64'd0);
        check("mid_rst_dividend", 64'(div_dividend), 64'd0);
        check("mid_rst_divisor", 64'(div_divisor), 64'd0);
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        req_dividend[1*SIZE +: SIZE] = 32'd81;
        req_divisor[1*SIZE +: SIZE]  = 32'd9;
        req_valid = 4'b1010;
        #1;
        check("post_rst_grant", 64'(req_ready), 64'b0010);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(starts);
        check("post_rst_id", 64'(rsp_id), 64'd1);
        check("post_rst_quotient", 64'(rsp_quotient), 64'd9);
        check("post_rst_remainder", 64'(rsp_remainder), 64'd0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench time limit");
    end

endmodule
